// File: rtl/sel_arbiter.sv
// sel_arbiter
// Two-requester arbiter that drives the select line of a downstream 2:1 mux.
// A newly chosen owner always gets exactly one dead cycle ("gap") between the
// sel change and its grant, so the mux output has settled before data is used.
// An owner that holds the grant for MAX_HOLD cycles while the other side is
// waiting is preempted. Ties go to the requester that did not own last.
//
// Ports
//   clk      : single clock, all state updates on the rising edge
//   rst      : synchronous, active-high reset (highest priority)
//   req_a    : request from source A (mux input a)
//   req_b    : request from source B (mux input b)
//   sel      : registered mux select, 0 = a, 1 = b
//   gnt_a    : registered grant to A (only ever high while sel = 0)
//   gnt_b    : registered grant to B (only ever high while sel = 1)
//   hold_cnt : registered count of cycles the current owner has held the grant
//   preempt  : registered one-cycle pulse when a grant is revoked by timeout
module sel_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  output logic       sel,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic [3:0] hold_cnt,
  output logic       preempt
);

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_last;       // last owner: 0 = A, 1 = B
  logic       r_sel;
  logic       r_gnt_a;
  logic       r_gnt_b;
  logic [3:0] r_hold_cnt;
  logic       r_preempt;

  // While a grant is active sel always points at the owner, so the owner's
  // and the other side's request can be picked straight off r_sel.
  logic w_owner_req;
  logic w_other_req;
  logic w_winner;

  assign w_owner_req = r_sel ? req_b : req_a;
  assign w_other_req = r_sel ? req_a : req_b;
  // Tie: the side that did not own last wins; otherwise whoever is asking.
  assign w_winner    = (req_a & req_b) ? ~r_last : req_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;   // makes A win the first tie after reset
      r_sel      <= 1'b0;
      r_gnt_a    <= 1'b0;
      r_gnt_b    <= 1'b0;
      r_hold_cnt <= 4'd0;
      r_preempt  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_gnt_a    <= 1'b0;
          r_gnt_b    <= 1'b0;
          r_hold_cnt <= 4'd0;
          r_preempt  <= 1'b0;
          if (req_a | req_b) begin
            r_sel   <= w_winner;
            r_state <= GAP;
          end
        end

        GAP: begin
          // Winner was fixed on entry (it is r_sel); requests are ignored here.
          r_gnt_a    <= ~r_sel;
          r_gnt_b    <= r_sel;
          r_hold_cnt <= 4'd1;
          r_last     <= r_sel;
          r_preempt  <= 1'b0;
          r_state    <= GRANT;
        end

        GRANT: begin
          if (!w_owner_req) begin
            // Normal release wins over a coincident timeout: no preempt pulse.
            r_gnt_a    <= 1'b0;
            r_gnt_b    <= 1'b0;
            r_hold_cnt <= 4'd0;
            r_preempt  <= 1'b0;
            if (w_other_req) begin
              r_sel   <= ~r_sel;
              r_state <= GAP;
            end else begin
              r_state <= IDLE;
            end
          end else if ((r_hold_cnt == HOLD_MAX) && w_other_req) begin
            r_gnt_a    <= 1'b0;
            r_gnt_b    <= 1'b0;
            r_hold_cnt <= 4'd0;
            r_preempt  <= 1'b1;
            r_sel      <= ~r_sel;
            r_state    <= GAP;
          end else begin
            r_preempt <= 1'b0;
            if (r_hold_cnt != HOLD_MAX) begin
              r_hold_cnt <= r_hold_cnt + 4'd1;
            end
          end
        end

        default: begin
          r_state    <= IDLE;
          r_gnt_a    <= 1'b0;
          r_gnt_b    <= 1'b0;
          r_hold_cnt <= 4'd0;
          r_preempt  <= 1'b0;
        end
      endcase
    end
  end

  assign sel      = r_sel;
  assign gnt_a    = r_gnt_a;
  assign gnt_b    = r_gnt_b;
  assign hold_cnt = r_hold_cnt;
  assign preempt  = r_preempt;

endmodule

// File: tb/tb_sel_arbiter.sv
// Testbench for sel_arbiter: a table of per-cycle vectors, a few hand-written
// multi-cycle sequences, then randomized requests compared against a
// cycle-level behavioural model, with per-cycle invariant checks throughout.
module tb_sel_arbiter;

  localparam int MH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic       sel;
  logic       gnt_a;
  logic       gnt_b;
  logic [3:0] hold_cnt;
  logic       preempt;

  always #5 clk = ~clk;

  sel_arbiter #(.MAX_HOLD(MH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_a    (req_a),
    .req_b    (req_b),
    .sel      (sel),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .hold_cnt (hold_cnt),
    .preempt  (preempt)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: owner = -1 when nobody holds the grant, gap = a
  // chosen winner is waiting out its dead cycle.
  int m_owner = -1;
  bit m_gap   = 0;
  int m_sel   = 0;
  int m_held  = 0;
  int m_pre   = 0;
  int m_last  = 1;

  task automatic model_edge();
    int r[2];
    int o;
    r[0] = int'(req_a);
    r[1] = int'(req_b);
    if (rst) begin
      m_owner = -1; m_gap = 0; m_sel = 0; m_held = 0; m_pre = 0; m_last = 1;
    end else if (m_gap) begin
      m_owner = m_sel; m_held = 1; m_last = m_sel; m_gap = 0; m_pre = 0;
    end else if (m_owner >= 0) begin
      o = m_owner;
      if (r[o] == 0) begin
        m_owner = -1; m_held = 0; m_pre = 0;
        if (r[1-o] != 0) begin m_sel = 1 - o; m_gap = 1; end
      end else if (m_held == MH && r[1-o] != 0) begin
        m_owner = -1; m_held = 0; m_pre = 1; m_sel = 1 - o; m_gap = 1;
      end else begin
        m_held = (m_held + 1 > MH) ? MH : m_held + 1;
        m_pre = 0;
      end
    end else begin
      m_pre = 0; m_held = 0;
      if (r[0] != 0 || r[1] != 0) begin
        m_sel = (r[0] != 0 && r[1] != 0) ? 1 - m_last : r[1];
        m_gap = 1;
      end
    end
  endtask

  logic prev_sel = 1'b0;

  // One clock: advance the model on the same inputs, then sample 1 time unit
  // after the edge and check the always-true invariants.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("gnt_exclusive", 32'(gnt_a & gnt_b), 0);
    if (gnt_a | gnt_b) chk("sel_stable_under_gnt", 32'(sel), 32'(prev_sel));
    if (gnt_a) chk("gnt_a_needs_sel0", 32'(sel), 0);
    if (gnt_b) chk("gnt_b_needs_sel1", 32'(sel), 1);
    prev_sel = sel;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    int rst, a, b;
    int e_sel, e_ga, e_gb, e_hold, e_pre;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // inputs before the edge -> outputs after the edge
    vecs[0]  = '{1, 0, 0,  0, 0, 0, 0, 0};  // reset
    vecs[1]  = '{0, 1, 1,  0, 0, 0, 0, 0};  // tie after reset: A wins, gap
    vecs[2]  = '{0, 1, 1,  0, 1, 0, 1, 0};  // gnt_a
    vecs[3]  = '{0, 0, 1,  1, 0, 0, 0, 0};  // A releases, B waiting -> gap, sel=1
    vecs[4]  = '{0, 1, 1,  1, 0, 1, 1, 0};  // gnt_b
    vecs[5]  = '{0, 1, 0,  0, 0, 0, 0, 0};  // B releases with A high -> gap, sel=0
    vecs[6]  = '{0, 1, 0,  0, 1, 0, 1, 0};  // gnt_a, no preempt
    vecs[7]  = '{0, 0, 0,  0, 0, 0, 0, 0};  // release to idle
    vecs[8]  = '{0, 0, 1,  1, 0, 0, 0, 0};  // B alone -> gap
    vecs[9]  = '{0, 0, 0,  1, 0, 1, 1, 0};  // req drop in gap ignored
    vecs[10] = '{0, 0, 1,  1, 0, 1, 2, 0};  // hold counts
    vecs[11] = '{1, 1, 1,  0, 0, 0, 0, 0};  // reset during gnt_b: no preempt
    vecs[12] = '{0, 1, 1,  0, 0, 0, 0, 0};  // tie after reset: A first
    vecs[13] = '{0, 1, 1,  0, 1, 0, 1, 0};
    vecs[14] = '{0, 0, 0,  0, 0, 0, 0, 0};
    vecs[15] = '{0, 0, 0,  0, 0, 0, 0, 0};  // idle keeps sel

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 16; i++) begin
      rst   = (vecs[i].rst != 0);
      req_a = (vecs[i].a != 0);
      req_b = (vecs[i].b != 0);
      step();
      chk($sformatf("vec%0d_sel", i),   32'(sel),      vecs[i].e_sel);
      chk($sformatf("vec%0d_gnt_a", i), 32'(gnt_a),    vecs[i].e_ga);
      chk($sformatf("vec%0d_gnt_b", i), 32'(gnt_b),    vecs[i].e_gb);
      chk($sformatf("vec%0d_hold", i),  32'(hold_cnt), vecs[i].e_hold);
      chk($sformatf("vec%0d_pre", i),   32'(preempt),  vecs[i].e_pre);
      $display("vec%0d: rst=%0d a=%0d b=%0d -> sel=%0d ga=%0d gb=%0d hold=%0d pre=%0d",
               i, rst, req_a, req_b, sel, gnt_a, gnt_b, hold_cnt, preempt);
    end

    // ---------------- both held: alternation with preemption ----------------
    do_reset();
    req_a = 1'b1; req_b = 1'b1;
    step();
    chk("alt_gap_sel", 32'(sel), 0);
    chk("alt_gap_ga", 32'(gnt_a), 0);
    for (int i = 1; i <= MH; i++) begin
      step();
      chk("alt_ga_on", 32'(gnt_a), 1);
      chk("alt_ga_hold", 32'(hold_cnt), 32'(i));
      chk("alt_ga_nopre", 32'(preempt), 0);
    end
    step();
    chk("alt_pre_a", 32'(preempt), 1);
    chk("alt_pre_sel", 32'(sel), 1);
    chk("alt_pre_gnts", 32'({gnt_a, gnt_b}), 0);
    for (int i = 1; i <= MH; i++) begin
      step();
      chk("alt_gb_on", 32'(gnt_b), 1);
      chk("alt_gb_hold", 32'(hold_cnt), 32'(i));
    end
    // owner releases exactly when a timeout would fire: plain release
    req_b = 1'b0;
    step();
    chk("coinc_pre", 32'(preempt), 0);
    chk("coinc_sel", 32'(sel), 0);
    chk("coinc_gnt_b", 32'(gnt_b), 0);
    step();
    chk("coinc_ga", 32'(gnt_a), 1);
    $display("seq alternation done");

    // ---------------- single requester saturates ----------------
    do_reset();
    req_a = 1'b1;
    step();
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("sat_ga", 32'(gnt_a), 1);
      chk("sat_pre", 32'(preempt), 0);
      chk("sat_hold", 32'(hold_cnt), 32'((i > MH) ? MH : i));
    end
    $display("seq saturation done hold=%0d", hold_cnt);

    // ---------------- reset during gap ----------------
    req_a = 1'b0;
    step();
    req_b = 1'b1;
    step();
    chk("gaprst_pre_sel", 32'(sel), 1);
    rst = 1'b1;
    step();
    rst = 1'b0; req_b = 1'b0;
    chk("gaprst_out", 32'({sel, gnt_a, gnt_b, preempt}), 0);
    chk("gaprst_hold", 32'(hold_cnt), 0);
    $display("seq reset-in-gap done");

    // ---------------- randomized vs model ----------------
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) req_a = ~req_a;
      if ($urandom_range(0, 5) == 0) req_b = ~req_b;
      rst = ($urandom_range(0, 199) == 0);
      step();
      chk("rnd_sel",   32'(sel),      32'(m_sel));
      chk("rnd_gnt_a", 32'(gnt_a),    32'(m_owner == 0));
      chk("rnd_gnt_b", 32'(gnt_b),    32'(m_owner == 1));
      chk("rnd_hold",  32'(hold_cnt), 32'(m_held));
      chk("rnd_pre",   32'(preempt),  32'(m_pre));
    end
    $display("random phase done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
